mem_req_bridge: RTL



---
 rtl/mem_req_bridge_pkg.sv | 22 ++
 rtl/mem_req_bridge_if.sv | 29 ++
 rtl/mem_req_bridge_perf_cnt.sv | 42 ++++
 rtl/mem_req_bridge.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_bridge_pkg.sv
// Shared definitions for the memory request bridge: FSM one-hot encodings,
// operation codes and the byte-strobe width derivation.
package mem_req_bridge_pkg;

    // One-hot FSM encodings
    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_REQ  = 4'b0010,
        S_RESP = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    // Latched operation type
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // One strobe bit per data byte
    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_req_bridge_if.sv
// Memory-side request/response channel of the bridge. The master modport is
// the bridge, the slave modport is the data memory.
interface mem_req_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = mem_req_bridge_pkg::strb_width(DATA_W);

    logic [ADDR_W-1:0] Address;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] Write_data;
    logic [STRB_W-1:0] Write_strb;
    logic              Mem_Req_Ready;
    logic [DATA_W-1:0] Read_data;
    logic              Read_data_Valid;
    logic              Read_data_Ready;

    modport master (
        output Address, MemRead, MemWrite, Write_data, Write_strb, Read_data_Ready,
        input  Mem_Req_Ready, Read_data, Read_data_Valid
    );

    modport slave (
        input  Address, MemRead, MemWrite, Write_data, Write_strb, Read_data_Ready,
        output Mem_Req_Ready, Read_data, Read_data_Valid
    );

endinterface

// File: rtl/mem_req_bridge_perf_cnt.sv
// Performance counters for the memory request bridge: completed reads,
// completed writes and cycles spent waiting on memory. All wrap on overflow.
// Only instantiated when MEM_BRIDGE_PERF_CNT_EN is defined.
module mem_bridge_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd_done,
    input  logic        i_wr_done,
    input  logic        i_stall,
    output logic [31:0] o_rd_cnt,
    output logic [31:0] o_wr_cnt,
    output logic [31:0] o_stall_cnt
);

    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;
    logic [31:0] r_stall_cnt;

    // Count completion and stall events, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_cnt    <= 32'd0;
            r_wr_cnt    <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (i_rd_done) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (i_wr_done) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
            if (i_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign o_rd_cnt    = r_rd_cnt;
    assign o_wr_cnt    = r_wr_cnt;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/mem_req_bridge.sv
// Bridge between the CPU MEM-stage one-shot strobes and a valid/ready memory
// request + read-response channel. Returns a one-cycle cpu_done pulse with
// latched read data. Optional perf counters: define MEM_BRIDGE_PERF_CNT_EN.
module mem_req_bridge
    import mem_req_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit ALIGN  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_req_rd,
    input  logic                          cpu_req_wr,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [DATA_W-1:0]             cpu_wdata,
    input  logic [strb_width(DATA_W)-1:0] cpu_wstrb,
    output logic [DATA_W-1:0]             cpu_rdata,
    output logic                          cpu_done,
    output logic                          cpu_busy,
    mem_req_bridge_if.master              mem
`ifdef MEM_BRIDGE_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_rd_cnt,
    output logic [31:0]                   perf_wr_cnt,
    output logic [31:0]                   perf_stall_cnt
`endif
);

    localparam int STRB_W = strb_width(DATA_W);

    state_t              r_state;
    state_t              w_next;
    logic                r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_req;
    logic [ADDR_W-1:0]   w_addr_in;
    logic                w_mem_read;
    logic                w_mem_write;
    logic [ADDR_W-1:0]   w_address;
    logic [DATA_W-1:0]   w_write_data;
    logic [STRB_W-1:0]   w_write_strb;
    logic                w_rd_ready;
    logic                w_done;
    logic                w_busy;

    assign w_req = cpu_req_wr | cpu_req_rd;

    // Memory-side address, word-aligned when ALIGN is set
    always_comb begin
        w_addr_in = cpu_addr;
        if (ALIGN) begin
            w_addr_in = {cpu_addr[ADDR_W-1:2], 2'b00};
        end else begin
            w_addr_in = cpu_addr;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = S_REQ;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem.Mem_Req_Ready) begin
                    w_next = (r_op == OP_WR) ? S_DONE : S_RESP;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_RESP: begin
                if (mem.Read_data_Valid) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_RESP;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Capture the CPU request when leaving IDLE; write wins over read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= OP_RD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if ((r_state == S_IDLE) && w_req) begin
            r_op    <= cpu_req_wr ? OP_WR : OP_RD;
            r_addr  <= w_addr_in;
            r_wdata <= cpu_wdata;
            r_wstrb <= cpu_wstrb;
        end
    end

    // Read data holds until the next completed read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if ((r_state == S_RESP) && mem.Read_data_Valid) begin
            r_rdata <= mem.Read_data;
        end
    end

    // FSM outputs; rst forces handshakes low in the same cycle it is seen
    always_comb begin
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_address    = '0;
        w_write_data = '0;
        w_write_strb = '0;
        w_rd_ready   = 1'b0;
        w_done       = 1'b0;
        w_busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
            end
            S_REQ: begin
                w_address = r_addr;
                if (r_op == OP_WR) begin
                    w_mem_write  = 1'b1;
                    w_write_data = r_wdata;
                    w_write_strb = r_wstrb;
                end else begin
                    w_mem_read   = 1'b1;
                end
            end
            S_RESP: begin
                w_rd_ready = 1'b1;
            end
            S_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b1;
            end
        endcase
        if (rst) begin
            w_mem_read   = 1'b0;
            w_mem_write  = 1'b0;
            w_address    = '0;
            w_write_data = '0;
            w_write_strb = '0;
            w_rd_ready   = 1'b0;
            w_done       = 1'b0;
            w_busy       = 1'b0;
        end else begin
            w_busy = w_busy;
        end
    end

    assign mem.MemRead         = w_mem_read;
    assign mem.MemWrite        = w_mem_write;
    assign mem.Address         = w_address;
    assign mem.Write_data      = w_write_data;
    assign mem.Write_strb      = w_write_strb;
    assign mem.Read_data_Ready = w_rd_ready;
    assign cpu_done            = w_done;
    assign cpu_busy            = w_busy;
    assign cpu_rdata           = r_rdata;

`ifdef MEM_BRIDGE_PERF_CNT_EN
    logic w_rd_done_evt;
    logic w_wr_done_evt;
    logic w_stall_evt;

    assign w_rd_done_evt = (r_state == S_DONE) && (r_op == OP_RD);
    assign w_wr_done_evt = (r_state == S_DONE) && (r_op == OP_WR);
    assign w_stall_evt   = (r_state == S_REQ) || (r_state == S_RESP);

    mem_bridge_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_rd_done   (w_rd_done_evt),
        .i_wr_done   (w_wr_done_evt),
        .i_stall     (w_stall_evt),
        .o_rd_cnt    (perf_rd_cnt),
        .o_wr_cnt    (perf_wr_cnt),
        .o_stall_cnt (perf_stall_cnt)
    );
`endif

endmodule
